name_stream_deframer: RTL and testbench
=======================================

// Module: name_stream_deframer
// PURPOSE
//  Parametrised successor to the name-field countdown decoder. Parses a framed
//  stream of read-name records: one header beat carries a beat count and channel
//  tag, then that many payload beats follow. Payload is forwarded with
//  valid/ready handshakes, end-of-record marking and per-channel tagging.
//  Sits between the compressed-stream fetch unit and the per-channel name decoders.
// PARAMETERS
//  DATA_W   128  payload width per beat
//  LEN_W    32   header beat-count field width
//  CH_W     2    header channel-tag field width (2**CH_W channels)
//  MAX_LEN  4096 largest legal beat count; larger records are consumed, not forwarded
//  IN_W  = LEN_W+DATA_W (localparam, 160 at defaults)
// PORTS
//  clk        in   1       sole clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_data    in   IN_W    header: [LEN_W-1:0]=N, [LEN_W+CH_W-1:LEN_W]=ch; payload: [IN_W-1:LEN_W]
//  in_valid   in   1       input beat valid
//  in_ready   out  1       input beat accepted when in_valid&&in_ready
//  out_data   out  DATA_W  forwarded payload beat
//  out_ch     out  CH_W    channel tag of the current record
//  out_last   out  1       final payload beat of the record
//  out_valid  out  1       output beat valid
//  out_ready  in   1       downstream accepts when out_valid&&out_ready
//  hdr_req    out  1       high while in S_HDR (awaiting a header beat; successor to RW)
//  rec_empty  out  1       one-cycle pulse: header with N==0 accepted
//  len_err    out  1       sticky: header with N>MAX_LEN accepted; cleared only by reset
//  rec_cnt    out  16      completed records (forwarded+empty+dropped), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async assert, sync-to-clk deassert upstream): state=S_HDR, remaining=0,
//   out_valid=0, out_data=0, out_ch=0, out_last=0, rec_empty=0, len_err=0, rec_cnt=0.
//   Reset mid-record discards the partial record; no out_last is produced for it.
//  States: S_HDR, S_PAY, S_DROP. All outputs registered except in_ready and hdr_req.
//  S_HDR: in_ready=1, hdr_req=1. On accepted beat, N=in_data[LEN_W-1:0]:
//   N==0       -> pulse rec_empty, rec_cnt++, stay in S_HDR.
//   N>MAX_LEN  -> set len_err, remaining=N, go to S_DROP.
//   otherwise  -> latch ch into out_ch, remaining=N, go to S_PAY.
//  S_PAY: in_ready = !out_valid || out_ready (single output register, no skid).
//   Accepted beat -> out_data=payload, out_valid=1 next cycle,
//   out_last=(remaining==1), remaining--. Last beat -> S_HDR, rec_cnt++.
//   out_data/out_ch/out_last held stable while out_valid && !out_ready.
//  S_DROP: in_ready=1, beats discarded, remaining--; at remaining==1 -> S_HDR, rec_cnt++.
//  Latency: payload beat accepted at cycle t is presented at t+1. Full throughput
//   (1 beat/cycle) when out_ready held high. Header-to-first-payload bubble: 0 cycles.
//  Last payload beat and the next header never share a cycle (header accepted in
//   S_HDR, earliest one cycle after last payload acceptance).
//  out_valid clears when out_ready=1 and no new beat accepted in the same cycle.
//  remaining is LEN_W bits, never underflows (only decremented when nonzero).
//  in_valid low: no state change; out side still drains.
// STRUCTURE
//  Shared package name_pkg: state enum encoding (S_HDR=0,S_PAY=1,S_DROP=2), header
//   field offsets, default DATA_W/LEN_W/CH_W/MAX_LEN constants.
//  One natural sub-module: name_beat_counter (loadable LEN_W down-counter with
//   is_one flag), reused by the record encoder.
// TESTING
//  1 Hdr N=3 ch=2, 3 payload beats A,B,C, out_ready=1 -> A,B,C out at t+1, out_ch=2,
//    out_last only on C, rec_cnt=1, hdr_req high again the cycle after C accepted.
//  2 Same record with out_ready toggling 1,0,0,1 -> no beat lost/duplicated, out_data
//    stable while stalled, in_ready low while out_valid&&!out_ready.
//  3 Hdr N=0 then hdr N=1 + beat D -> rec_empty 1-cycle pulse, no out_valid for first,
//    D with out_last=1, rec_cnt=2.
//  4 Hdr N=MAX_LEN+1 followed by MAX_LEN+1 beats -> len_err=1 sticky, out_valid never
//    asserted, rec_cnt=1, next normal record forwarded correctly.
//  5 rst_n low mid S_PAY after 2 of 5 beats -> all outputs zero immediately, state S_HDR,
//    hdr_req=1 after release, fresh N=1 record forwarded normally.
//  6 Preload 65535 empty records -> rec_cnt wraps 0xFFFF->0 on the 65536th.

Source files
------------

// File: rtl/name_pkg.sv
// Shared definitions for the name-record stream deframer.
//   - state_t        : deframer FSM state encoding
//   - DEF_*          : default geometry of the stream
//   - HDR_LEN_LSB    : LSB of the beat-count field in a header beat
//   - hdr_ch_lsb()   : LSB of the channel-tag field, which sits directly above the
//                      beat count; payload beats also start at that offset
package name_pkg;

    localparam int DEF_DATA_W  = 128;
    localparam int DEF_LEN_W   = 32;
    localparam int DEF_CH_W    = 2;
    localparam int DEF_MAX_LEN = 4096;

    localparam int HDR_LEN_LSB = 0;

    function automatic int hdr_ch_lsb(input int len_w);
        return len_w;
    endfunction

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } state_t;

endpackage

// File: rtl/name_beat_counter.sv
// Loadable down-counter that tracks the beats still owed by the current record.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : new beat count
//   dec        : consume one beat; ignored at zero so the count never underflows
//   is_one     : the next consumed beat is the last one of the record
module name_beat_counter
    import name_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [LEN_W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == LEN_W'(1));

endmodule

// File: rtl/name_stream_deframer.sv
// Parses a framed stream of read-name records. A header beat carries a beat count N
// and a channel tag; N payload beats follow and are forwarded with valid/ready,
// end-of-record marking and the record's channel tag. Records longer than MAX_LEN
// are consumed without being forwarded.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/valid/ready : input beats; header = {.., ch, N}, payload = {data, LEN_W'x}
//   out_data/ch/last    : forwarded payload beat, its channel, end-of-record flag
//   out_valid/ready     : output handshake (single output register, no skid)
//   hdr_req             : waiting for a header beat
//   rec_empty           : one-cycle pulse on an accepted N==0 header
//   len_err             : sticky, an oversize header was seen
//   rec_cnt             : completed records (forwarded, empty and dropped), wraps
module name_stream_deframer
    import name_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CH_W    = DEF_CH_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    localparam int IN_W   = LEN_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              hdr_req,
    output logic              rec_empty,
    output logic              len_err,
    output logic [15:0]       rec_cnt
);

    localparam int               CH_LSB    = hdr_ch_lsb(LEN_W);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_t state, state_nxt;

    logic [LEN_W-1:0]  hdr_len;
    logic [CH_W-1:0]   hdr_ch;
    logic [DATA_W-1:0] payload;
    logic [CH_W-1:0]   rec_ch;
    logic              is_one;

    logic hdr_zero, hdr_big, hdr_ok;
    logic pay_acc, drop_acc, rec_done;

    assign hdr_len = in_data[HDR_LEN_LSB +: LEN_W];
    assign hdr_ch  = in_data[CH_LSB +: CH_W];
    assign payload = in_data[IN_W-1:LEN_W];

    // NOTE: every output of this block gets a default first, so no path through
    // the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        hdr_req   = 1'b0;
        hdr_zero  = 1'b0;
        hdr_big   = 1'b0;
        hdr_ok    = 1'b0;
        pay_acc   = 1'b0;
        drop_acc  = 1'b0;
        rec_done  = 1'b0;
        case (state)
            S_HDR: begin
                in_ready = 1'b1;
                hdr_req  = 1'b1;
                if (in_valid) begin
                    if (hdr_len == '0) begin
                        hdr_zero = 1'b1;
                        rec_done = 1'b1;
                    end else if (hdr_len > MAX_LEN_V) begin
                        hdr_big   = 1'b1;
                        state_nxt = S_DROP;
                    end else begin
                        hdr_ok    = 1'b1;
                        state_nxt = S_PAY;
                    end
                end
            end
            S_PAY: begin
                // A new beat may enter only if the output register is free or
                // being emptied this cycle.
                in_ready = !out_valid || out_ready;
                pay_acc  = in_valid && in_ready;
                if (pay_acc && is_one) begin
                    rec_done  = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            S_DROP: begin
                in_ready = 1'b1;
                drop_acc = in_valid;
                if (drop_acc && is_one) begin
                    rec_done  = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            default: state_nxt = S_HDR;
        endcase
    end

    name_beat_counter #(.LEN_W(LEN_W)) u_remaining (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hdr_ok || hdr_big),
        .load_val (hdr_len),
        .dec      (pay_acc || drop_acc),
        .is_one   (is_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HDR;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            rec_ch    <= '0;
            rec_empty <= 1'b0;
            len_err   <= 1'b0;
            rec_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            rec_empty <= hdr_zero;
            if (hdr_big) begin
                len_err <= 1'b1;
            end
            if (rec_done) begin
                rec_cnt <= rec_cnt + 16'd1;
            end
            if (pay_acc) begin
                out_valid <= 1'b1;
                out_data  <= payload;
                out_last  <= is_one;
                out_ch    <= rec_ch;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // The previous record's last beat may still be stalled when the next
            // header arrives; out_ch then waits for the first payload beat, taken
            // from rec_ch, so the stalled beat keeps its own tag.
            if (hdr_ok) begin
                rec_ch <= hdr_ch;
                if (!(out_valid && !out_ready)) begin
                    out_ch <= hdr_ch;
                end
            end
        end
    end

endmodule

// File: tb/tb_name_stream_deframer.sv
module tb_name_stream_deframer;

    localparam int DATA_W  = 128;
    localparam int LEN_W   = 32;
    localparam int CH_W    = 2;
    localparam int MAX_LEN = 4096;
    localparam int IN_W    = LEN_W + DATA_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              hdr_req;
    logic              rec_empty;
    logic              len_err;
    logic [15:0]       rec_cnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;
    int   drop_ov  = 0;
    logic in_drop  = 1'b0;

    always #5 clk = ~clk;

    name_stream_deframer #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .CH_W(CH_W), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .hdr_req(hdr_req), .rec_empty(rec_empty), .len_err(len_err), .rec_cnt(rec_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [IN_W-1:0] mk_hdr(input int unsigned n, input int unsigned ch);
        return {{(DATA_W-CH_W){1'b0}}, CH_W'(ch), LEN_W'(n)};
    endfunction

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one beat and return #1 after the edge that accepts it.
    task automatic send(input logic [IN_W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (in_ready) break;
            if (k > 200) begin
                check("send_timeout_in_ready", in_ready, 1'b1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [DATA_W-1:0] d, input int unsigned ch, input logic last);
        sb.push_back('{data: d, ch: CH_W'(ch), last: last});
        send({d, {LEN_W{1'b0}}});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: a beat transfers at the edge following a negedge that sees
    // out_valid && out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (in_drop) drop_ov++;
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_ch",   out_ch,   e.ch);
                    check("out_last", out_last, e.last);
                end
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] a, b, c, d;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        idle(3);

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  '0);
        check("rst_out_ch",    out_ch,    '0);
        check("rst_out_last",  out_last,  1'b0);
        check("rst_rec_empty", rec_empty, 1'b0);
        check("rst_len_err",   len_err,   1'b0);
        check("rst_rec_cnt",   rec_cnt,   '0);
        rst_n = 1'b1;
        idle(1);
        check("rst_hdr_req",  hdr_req,  1'b1);
        check("rst_in_ready", in_ready, 1'b1);

        // 1: N=3 ch=2, full throughput, one-cycle latency
        out_ready = 1'b1;
        a = rnd_data(); b = rnd_data(); c = rnd_data();
        send(mk_hdr(3, 2));
        check("t1_hdr_req_low", hdr_req, 1'b0);
        send_pay(a, 2, 1'b0);
        check("t1_latency_valid", out_valid, 1'b1);
        check("t1_latency_data",  out_data,  a);
        send_pay(b, 2, 1'b0);
        send_pay(c, 2, 1'b1);
        exp_cnt++;
        check("t1_hdr_req_after_last", hdr_req, 1'b1);
        check("t1_rec_cnt", rec_cnt, 16'(exp_cnt));
        idle(2);
        check("t1_drained", out_valid, 1'b0);

        // 2: out_ready 1,0,0,1 during the record
        a = rnd_data(); b = rnd_data(); c = rnd_data();
        send(mk_hdr(3, 2));
        send_pay(a, 2, 1'b0);
        out_ready = 1'b0;
        in_data   = {b, {LEN_W{1'b0}}};
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t2_in_ready_stalled", in_ready, 1'b0);
            check("t2_out_valid_held",   out_valid, 1'b1);
            check("t2_out_data_held",    out_data, a);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_pay(b, 2, 1'b0);
        send_pay(c, 2, 1'b1);
        exp_cnt++;
        idle(2);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_rec_cnt",  rec_cnt, 16'(exp_cnt));

        // 3: empty record then N=1
        send(mk_hdr(0, 1));
        exp_cnt++;
        check("t3_rec_empty_pulse", rec_empty, 1'b1);
        check("t3_no_out_valid",    out_valid, 1'b0);
        check("t3_hdr_req",         hdr_req,   1'b1);
        idle(1);
        check("t3_rec_empty_cleared", rec_empty, 1'b0);
        d = rnd_data();
        send(mk_hdr(1, 3));
        send_pay(d, 3, 1'b1);
        exp_cnt++;
        idle(2);
        check("t3_rec_cnt", rec_cnt, 16'(exp_cnt));

        // 4: oversize record dropped, then a normal record
        in_drop = 1'b1;
        send(mk_hdr(MAX_LEN + 1, 1));
        check("t4_len_err_set", len_err, 1'b1);
        for (int i = 0; i < MAX_LEN + 1; i++) begin
            send({rnd_data(), {LEN_W{1'b0}}});
        end
        exp_cnt++;
        check("t4_hdr_req_after_drop", hdr_req, 1'b1);
        idle(1);
        in_drop = 1'b0;
        check("t4_no_out_during_drop", drop_ov, 0);
        check("t4_rec_cnt", rec_cnt, 16'(exp_cnt));
        a = rnd_data(); b = rnd_data();
        send(mk_hdr(2, 0));
        send_pay(a, 0, 1'b0);
        send_pay(b, 0, 1'b1);
        exp_cnt++;
        idle(2);
        check("t4_len_err_sticky", len_err, 1'b1);
        check("t4_rec_cnt_after", rec_cnt, 16'(exp_cnt));

        // 5: reset in the middle of a record
        send(mk_hdr(5, 1));
        send_pay(rnd_data(), 1, 1'b0);
        send_pay(rnd_data(), 1, 1'b0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt = 0;
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_out_data",  out_data,  '0);
        check("t5_out_ch",    out_ch,    '0);
        check("t5_out_last",  out_last,  1'b0);
        check("t5_len_err",   len_err,   1'b0);
        check("t5_rec_cnt",   rec_cnt,   '0);
        check("t5_hdr_req",   hdr_req,   1'b1);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        check("t5_hdr_req_after_release", hdr_req, 1'b1);
        d = rnd_data();
        send(mk_hdr(1, 2));
        send_pay(d, 2, 1'b1);
        exp_cnt++;
        idle(2);
        check("t5_rec_cnt_after", rec_cnt, 16'(exp_cnt));

        // 6: rec_cnt wrap via back-to-back empty headers
        in_data  = mk_hdr(0, 0);
        in_valid = 1'b1;
        repeat (65535 - exp_cnt) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t6_rec_cnt_ffff", rec_cnt, 16'hFFFF);
        send(mk_hdr(0, 0));
        check("t6_rec_cnt_wrap", rec_cnt, 16'h0000);
        idle(2);
        check("t6_no_out_valid", out_valid, 1'b0);
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
